// File: rtl/leaf_stream_arbiter.sv
// Round-robin arbiter sharing one ap_vld/ap_ack leaf lane among NUM_REQ producer streams.
// Optional LEAF_ARB_STATS_EN adds word_count / grant_count statistics outputs.
module leaf_stream_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            vld_out,
  input  logic                            ack_in,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [31:0]                     word_count,
  output logic [31:0]                     grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [IDX_W-1:0]   pick_idx, grant_inc;
  logic [IDX_W:0]     best_off;
  logic               pick_found, sel_vld, xfer;

  logic [PAYLOAD_BITS-1:0] din_arr [NUM_REQ];
  logic [IDX_W:0]          req_off [NUM_REQ];

  // req_off is each requester's circular distance above rr_ptr; smallest valid one wins.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign din_arr[gi] = din_req[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign ack_req[gi] = busy && ack_in && (grant_idx_reg == IDX_W'(gi));
      assign req_off[gi] = (IDX_W'(gi) >= rr_ptr_reg)
                         ? ({1'b0, IDX_W'(gi)} - {1'b0, rr_ptr_reg})
                         : ({1'b0, IDX_W'(gi)} + (IDX_W+1)'(NUM_REQ) - {1'b0, rr_ptr_reg});
    end
  endgenerate

  assign busy      = (state_reg == GRANT);
  assign grant_idx = grant_idx_reg;
  assign dout      = din_arr[grant_idx_reg];
  assign sel_vld   = vld_req[grant_idx_reg];
  assign vld_out   = busy && sel_vld;
  assign xfer      = vld_out && ack_in;
  assign grant_inc = (grant_idx_reg == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_reg + 1'b1;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best_off   = (IDX_W+1)'(NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vld_req[i] && (req_off[i] < best_off)) begin
        best_off   = req_off[i];
        pick_idx   = IDX_W'(i);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next     = GRANT;
          grant_idx_next = pick_idx;
          burst_cnt_next = '0;
        end
      end
      GRANT: begin
        // A drained stream and a completed burst both end the grant; backpressure never does.
        if (!sel_vld || (xfer && (burst_cnt_reg == CNT_W'(MAX_BURST-1)))) begin
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
        end else if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

`ifdef LEAF_ARB_STATS_EN
  logic [31:0] word_count_reg, grant_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count_reg  <= '0;
      grant_count_reg <= '0;
    end else begin
      if (xfer)
        word_count_reg <= word_count_reg + 32'd1;
      if ((state_reg == IDLE) && pick_found)
        grant_count_reg <= grant_count_reg + 32'd1;
    end
  end

  assign word_count  = word_count_reg;
  assign grant_count = grant_count_reg;
`endif

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Scoreboard bench for leaf_stream_arbiter: producer models feed directed bursts,
// a monitor checks every leaf-side transfer against queued expectations.
module tb_leaf_stream_arbiter;

  localparam int NR = 3;
  localparam int PB = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR*PB-1:0]  din_req;
  logic [NR-1:0]     vld_req;
  logic [NR-1:0]     ack_req;
  logic [PB-1:0]     dout;
  logic              vld_out;
  logic              ack_in = 1'b1;
  logic [1:0]        grant_idx;
  logic              busy;
`ifdef LEAF_ARB_STATS_EN
  logic [31:0]       word_count, grant_count;
`endif

  leaf_stream_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .din_req(din_req), .vld_req(vld_req), .ack_req(ack_req),
    .dout(dout), .vld_out(vld_out), .ack_in(ack_in), .grant_idx(grant_idx), .busy(busy)
`ifdef LEAF_ARB_STATS_EN
    , .word_count(word_count), .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          gap;   // non-transfer cycles since previous transfer, -1 = don't care
  } exp_t;

  exp_t        sb[$];
  logic [31:0] src_q [NR][$];
  logic [NR-1:0] acc;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int r, input int k);
    return 32'hA000_0000 | 32'(r << 16) | 32'(k);
  endfunction

  task automatic feed(input int r, input int first, input int n);
    for (int k = first; k < first + n; k++) src_q[r].push_back(wd(r, k));
  endtask

  task automatic expect_words(input int r, input int first, input int n, input int gap_first);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = r;
      e.data = wd(r, first + k);
      e.gap  = (k == 0) ? gap_first : 0;
      sb.push_back(e);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      vld_req[i] = (src_q[i].size() > 0);
      din_req[i*PB +: PB] = (src_q[i].size() > 0) ? src_q[i][0] : (32'hDEAD_0000 | 32'(i));
    end
  endtask

  // Producer model: holds head word until the edge on which it was acked.
  initial begin
    refresh();
    forever begin
      @(negedge clk);
      acc = ack_req & vld_req;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      refresh();
    end
  end

  // Monitor: every leaf-side transfer must match the scoreboard head.
  initial begin
    exp_t e;
    int   gap;
    gap = 0;
    forever begin
      @(negedge clk);
      if (!reset && vld_out && ack_in) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer actual idx=%0d data=%h required none", grant_idx, dout);
        end else begin
          e = sb.pop_front();
          $display("xfer req=%0d data=%h gap=%0d", grant_idx, dout, gap);
          chk("xfer_idx", 64'(grant_idx), 64'(e.idx));
          chk("xfer_data", 64'(dout), 64'(e.data));
          chk("xfer_ack", 64'(ack_req), 64'(1 << e.idx));
          if (e.gap >= 0) chk("xfer_gap", 64'(gap), 64'(e.gap));
        end
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            src_q[2].size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, sb.size());
      sb.delete();
      for (int i = 0; i < NR; i++) src_q[i].delete();
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_idle"}, 64'(busy), 64'(0));
    @(posedge clk);
    #3;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_vld_out", 64'(vld_out), 64'(0));
    chk("rst_ack_req", 64'(ack_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_idx", 64'(grant_idx), 64'(0));
    chk("rst_dout", 64'(dout), 64'h0000_0000_DEAD_0000);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #3;

    // Single requester, 40 words: bursts of 16,16,8 with one bubble between
    feed(1, 0, 40);
    expect_words(1, 0, 16, -1);
    expect_words(1, 16, 16, 1);
    expect_words(1, 32, 8, 1);
    wait_drain("single_stream");

    // All three continuously valid: 0,1,2,0,1,2 with 16 words each
    reset_pulse();
    for (int r = 0; r < NR; r++) feed(r, 0, 32);
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NR; r++)
        expect_words(r, b * 16, 16, (b == 0 && r == 0) ? -1 : 1);
    wait_drain("round_robin");

    // Backpressure: grant to 2 held for 50 cycles without ack
    ack_in = 1'b0;
    feed(2, 0, 2);
    expect_words(2, 0, 2, -1);
    repeat (2) @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("hold_grant", {vld_out, busy, 30'd0, grant_idx, dout},
          {1'b1, 1'b1, 30'd0, 2'd2, wd(2, 0)});
    end
    @(posedge clk);
    #3 ack_in = 1'b1;
    wait_drain("backpressure");

    // Requester 0 drains after 3 words while 1 waits
    feed(0, 0, 3);
    feed(1, 0, 4);
    expect_words(0, 0, 3, -1);
    expect_words(1, 0, 4, 2);
    wait_drain("drain_release");

    // Reset after 7 of 16 words; arbitration restarts at requester 0
    feed(1, 0, 16);
    expect_words(1, 0, 7, -1);
    n = 0;
    while (src_q[1].size() != 9 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL mid_burst_timeout actual left=%0d required 9", src_q[1].size());
    end
    chk("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_vld_out", 64'(vld_out), 64'(0));
    chk("async_rst_ack_req", 64'(ack_req), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_grant", 64'(grant_idx), 64'(0));
    feed(0, 0, 2);
    feed(2, 0, 2);
    expect_words(0, 0, 2, -1);
    expect_words(1, 7, 9, 2);
    expect_words(2, 0, 2, 2);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    wait_drain("reset_restart");

    // 3 requesters x 20 words: six grants, 60 words
    reset_pulse();
    for (int r = 0; r < NR; r++) feed(r, 0, 20);
    expect_words(0, 0, 16, -1);
    expect_words(1, 0, 16, 1);
    expect_words(2, 0, 16, 1);
    expect_words(0, 16, 4, 1);
    expect_words(1, 16, 4, 2);
    expect_words(2, 16, 4, 2);
    wait_drain("stats_traffic");
`ifdef LEAF_ARB_STATS_EN
    chk("word_count", 64'(word_count), 64'd60);
    chk("grant_count", 64'(grant_count), 64'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
